// File: rtl/clk_rst_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : clk_rst_sequencer
// Brief    : Releases a bank of resets in order once PLL lock is proven stable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module clk_rst_sequencer #(
  parameter int N_OUTPUTS          = 4,
  parameter int LOCK_SYNC_STAGES   = 2,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STAGE_DELAY        = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int PLL_RST_CYCLES     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 ext_hold,
  input  logic                 clr_lock_lost,
  output logic [N_OUTPUTS-1:0] rst_out,
  output logic                 pll_rst,
  output logic                 seq_done,
  output logic                 lock_lost,
  output logic [7:0]           retry_cnt,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_PLL_RESET = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  // One shared counter serves every timed state, so size it for the longest.
  localparam int c_MAX_A   = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
  localparam int c_MAX_B   = (STAGE_DELAY > PLL_RST_CYCLES) ? STAGE_DELAY : PLL_RST_CYCLES;
  localparam int c_CNT_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);
  localparam int c_IDX_W   = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1;

  localparam logic [c_CNT_W-1:0]   c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]   c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]   c_STAGE_LAST   = c_CNT_W'(STAGE_DELAY - 1);
  localparam logic [c_CNT_W-1:0]   c_PLLRST_LAST  = c_CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST     = c_IDX_W'(N_OUTPUTS - 1);
  localparam logic [N_OUTPUTS-1:0] c_ALL_ONES     = '1;

  logic [LOCK_SYNC_STAGES-1:0] r_sync;
  state_t                      r_state;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_IDX_W-1:0]          r_idx;
  logic [N_OUTPUTS-1:0]        r_rst_out;
  logic                        r_pll_rst;
  logic                        r_seq_done;
  logic                        r_lock_lost;
  logic [7:0]                  r_retry;

  state_t                      w_state;
  logic [c_CNT_W-1:0]          w_cnt;
  logic [c_IDX_W-1:0]          w_idx;
  logic [N_OUTPUTS-1:0]        w_rst_out;
  logic                        w_pll_rst;
  logic                        w_seq_done;
  logic                        w_lock_lost;
  logic [7:0]                  w_retry;
  logic                        w_set_lost;
  logic                        w_locked_s;
  logic [7:0]                  w_retry_inc;

  assign w_locked_s  = r_sync[LOCK_SYNC_STAGES-1];
  assign w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[LOCK_SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_out   <= c_ALL_ONES;
      r_pll_rst   <= 1'b0;
      r_seq_done  <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry     <= 8'd0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_rst_out   <= w_rst_out;
      r_pll_rst   <= w_pll_rst;
      r_seq_done  <= w_seq_done;
      r_lock_lost <= w_lock_lost;
      r_retry     <= w_retry;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_rst_out  = r_rst_out;
    w_pll_rst  = r_pll_rst;
    w_seq_done = r_seq_done;
    w_retry    = r_retry;
    w_set_lost = 1'b0;

    case (r_state)
      S_WAIT_LOCK: begin
        w_rst_out  = c_ALL_ONES;
        w_seq_done = 1'b0;
        w_pll_rst  = 1'b0;
        if (w_locked_s) begin
          w_state = S_STABLE;
          w_cnt   = '0;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_state   = S_PLL_RESET;
          w_cnt     = '0;
          w_pll_rst = 1'b1;
          w_retry   = w_retry_inc;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_PLL_RESET: begin
        if (r_cnt == c_PLLRST_LAST) begin
          w_state   = S_WAIT_LOCK;
          w_cnt     = '0;
          w_pll_rst = 1'b0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_STABLE: begin
        if (!w_locked_s) begin
          w_state = S_WAIT_LOCK;
          w_cnt   = '0;
        end else if (ext_hold) begin
          w_state = S_HOLD;
          w_cnt   = '0;
        end else if (r_cnt == c_STABLE_LAST) begin
          w_state   = S_RELEASE;
          w_cnt     = '0;
          w_idx     = '0;
          w_rst_out = c_ALL_ONES;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_RELEASE, S_RUN: begin
        // Lock loss is checked before hold so it wins and gets flagged.
        if (!w_locked_s) begin
          w_set_lost = 1'b1;
          w_state    = S_WAIT_LOCK;
          w_cnt      = '0;
          w_idx      = '0;
          w_rst_out  = c_ALL_ONES;
          w_seq_done = 1'b0;
        end else if (ext_hold) begin
          w_state    = S_HOLD;
          w_cnt      = '0;
          w_idx      = '0;
          w_rst_out  = c_ALL_ONES;
          w_seq_done = 1'b0;
        end else if (r_state == S_RELEASE) begin
          if (r_cnt == c_STAGE_LAST) begin
            w_cnt = '0;
            for (int k = 0; k < N_OUTPUTS; k++) begin
              if (r_idx == c_IDX_W'(k)) begin
                w_rst_out[k] = 1'b0;
              end
            end
            if (r_idx == c_IDX_LAST) begin
              w_state    = S_RUN;
              w_seq_done = 1'b1;
            end else begin
              w_idx = r_idx + 1'b1;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end

      S_HOLD: begin
        w_rst_out  = c_ALL_ONES;
        w_seq_done = 1'b0;
        if (!ext_hold) begin
          w_state = S_WAIT_LOCK;
          w_cnt   = '0;
        end
      end

      default: begin
        w_state    = S_WAIT_LOCK;
        w_cnt      = '0;
        w_idx      = '0;
        w_rst_out  = c_ALL_ONES;
        w_pll_rst  = 1'b0;
        w_seq_done = 1'b0;
      end
    endcase

    if (w_set_lost) begin
      w_lock_lost = 1'b1;
    end else if (clr_lock_lost) begin
      w_lock_lost = 1'b0;
    end else begin
      w_lock_lost = r_lock_lost;
    end
  end

  assign rst_out   = r_rst_out;
  assign pll_rst   = r_pll_rst;
  assign seq_done  = r_seq_done;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_clk_rst_sequencer
// Brief    : Scoreboard bench; expectations are timed by clock edge number.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_clk_rst_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       ext_hold;
  logic       clr_lock_lost;
  logic [2:0] rst_out;
  logic       pll_rst;
  logic       seq_done;
  logic       lock_lost;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  typedef struct {
    int          cyc;
    string       tag;
    logic [16:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  clk_rst_sequencer #(
    .N_OUTPUTS         (3),
    .LOCK_SYNC_STAGES  (2),
    .LOCK_STABLE_CYCLES(8),
    .STAGE_DELAY       (4),
    .LOCK_TIMEOUT      (32),
    .PLL_RST_CYCLES    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .ext_hold     (ext_hold),
    .clr_lock_lost(clr_lock_lost),
    .rst_out      (rst_out),
    .pll_rst      (pll_rst),
    .seq_done     (seq_done),
    .lock_lost    (lock_lost),
    .retry_cnt    (retry_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {rst_out, seq_done, lock_lost, pll_rst, retry_cnt, state}
  function automatic logic [16:0] pk(input logic [2:0] ro, input logic sd, input logic ll,
                                     input logic pr, input logic [7:0] rc, input logic [2:0] st);
    return {ro, sd, ll, pr, rc, st};
  endfunction

  function automatic logic [16:0] obs();
    return {rst_out, seq_done, lock_lost, pll_rst, retry_cnt, state};
  endfunction

  function automatic void push(input int c, input string t, input logic [16:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [16:0] o;
    rst = 1'b1; pll_locked = 1'b0; ext_hold = 1'b0; clr_lock_lost = 1'b0;
    tick();
    tick();
    o = obs();
    n_checks++;
    if (o !== pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0))
      $display("FAIL reset_values got %b required %b", o, pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    else n_pass++;
  endtask

  task automatic test_nominal();
    int base;
    exp_t e;
    logic [16:0] o;
    pll_locked = 1'b1;
    tick();
    rst = 1'b0;
    base = cyc;
    push(base + 2,  "nom_wait",    pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    push(base + 3,  "nom_stable",  pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 10, "nom_stable7", pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 11, "nom_release", pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 14, "nom_pre0",    pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 15, "nom_rel0",    pk(3'b110, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 19, "nom_rel1",    pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 22, "nom_pre2",    pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 23, "nom_done",    pk(3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3));
    push(base + 30, "nom_run",     pk(3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3));
    for (int i = 1; i <= 30; i++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs();
        n_checks++;
        if (o !== e.val)
          $display("FAIL %s cyc=%0d got ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d required ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d",
                   e.tag, cyc - base, o[16:14], o[13], o[12], o[11], o[10:3], o[2:0],
                   e.val[16:14], e.val[13], e.val[12], e.val[11], e.val[10:3], e.val[2:0]);
        else n_pass++;
      end
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL nominal_pending got %0d unchecked required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_hold();
    int base;
    exp_t e;
    logic [16:0] o;
    base = cyc;
    push(base + 1,  "hold_enter", pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd5));
    push(base + 10, "hold_stay",  pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd5));
    push(base + 11, "hold_exit",  pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    push(base + 12, "hold_stab",  pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 19, "hold_stab7", pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 20, "hold_rel",   pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 24, "hold_rel0",  pk(3'b110, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 28, "hold_rel1",  pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 32, "hold_done",  pk(3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3));
    for (int i = 1; i <= 33; i++) begin
      ext_hold = (i <= 10);
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs();
        n_checks++;
        if (o !== e.val)
          $display("FAIL %s cyc=%0d got ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d required ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d",
                   e.tag, cyc - base, o[16:14], o[13], o[12], o[11], o[10:3], o[2:0],
                   e.val[16:14], e.val[13], e.val[12], e.val[11], e.val[10:3], e.val[2:0]);
        else n_pass++;
      end
    end
    ext_hold = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL hold_pending got %0d unchecked required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    int base;
    exp_t e;
    logic [16:0] o;
    rst = 1'b1; pll_locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    base = cyc;
    push(base + 3,  "gl_stable",   pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 7,  "gl_stable4",  pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 8,  "gl_drop",     pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    push(base + 9,  "gl_restable", pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 16, "gl_full8",    pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1));
    push(base + 17, "gl_release",  pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 21, "gl_rel0",     pk(3'b110, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 25, "gl_rel1",     pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 29, "gl_done",     pk(3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3));
    for (int i = 1; i <= 30; i++) begin
      pll_locked = (i <= 5) || (i >= 7);
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs();
        n_checks++;
        if (o !== e.val)
          $display("FAIL %s cyc=%0d got ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d required ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d",
                   e.tag, cyc - base, o[16:14], o[13], o[12], o[11], o[10:3], o[2:0],
                   e.val[16:14], e.val[13], e.val[12], e.val[11], e.val[10:3], e.val[2:0]);
        else n_pass++;
      end
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL glitch_pending got %0d unchecked required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lock_loss();
    int base;
    exp_t e;
    logic [16:0] o;
    rst = 1'b1; pll_locked = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    base = cyc;
    push(base + 15, "ll_rel0",      pk(3'b110, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 17, "ll_latency",   pk(3'b110, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    push(base + 18, "ll_lost",      pk(3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0));
    push(base + 21, "ll_waiting",   pk(3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0));
    push(base + 22, "ll_relock",    pk(3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 3'd1));
    push(base + 29, "ll_stable7",   pk(3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 3'd1));
    push(base + 30, "ll_release",   pk(3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2));
    push(base + 34, "ll_rel0b",     pk(3'b110, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2));
    push(base + 38, "ll_rel1b",     pk(3'b100, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2));
    push(base + 42, "ll_done",      pk(3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 3'd3));
    push(base + 46, "ll_run",       pk(3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 3'd3));
    push(base + 47, "ll_set_vs_clr", pk(3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0));
    push(base + 49, "ll_sticky",    pk(3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0));
    push(base + 50, "ll_cleared",   pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    for (int i = 1; i <= 52; i++) begin
      pll_locked    = !(i >= 16 && i < 20) && !(i >= 45);
      clr_lock_lost = (i == 47) || (i == 50);
      ext_hold      = (i == 47);
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs();
        n_checks++;
        if (o !== e.val)
          $display("FAIL %s cyc=%0d got ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d required ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d",
                   e.tag, cyc - base, o[16:14], o[13], o[12], o[11], o[10:3], o[2:0],
                   e.val[16:14], e.val[13], e.val[12], e.val[11], e.val[10:3], e.val[2:0]);
        else n_pass++;
      end
    end
    clr_lock_lost = 1'b0;
    ext_hold      = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL lockloss_pending got %0d unchecked required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int base;
    exp_t e;
    logic [16:0] o;
    rst = 1'b1; pll_locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    base = cyc;
    push(base + 31, "to_wait31", pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    push(base + 32, "to_pulse1", pk(3'b111, 1'b0, 1'b0, 1'b1, 8'd1, 3'd4));
    push(base + 34, "to_pulse3", pk(3'b111, 1'b0, 1'b0, 1'b1, 8'd1, 3'd4));
    push(base + 35, "to_end1",   pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd1, 3'd0));
    push(base + 66, "to_wait2",  pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd1, 3'd0));
    push(base + 67, "to_pulse2", pk(3'b111, 1'b0, 1'b0, 1'b1, 8'd2, 3'd4));
    push(base + 69, "to_pulse2c", pk(3'b111, 1'b0, 1'b0, 1'b1, 8'd2, 3'd4));
    push(base + 70, "to_end2",   pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd2, 3'd0));
    for (int i = 1; i <= 72; i++) begin
      ext_hold = (i >= 20 && i <= 40);
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs();
        n_checks++;
        if (o !== e.val)
          $display("FAIL %s cyc=%0d got ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d required ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d",
                   e.tag, cyc - base, o[16:14], o[13], o[12], o[11], o[10:3], o[2:0],
                   e.val[16:14], e.val[13], e.val[12], e.val[11], e.val[10:3], e.val[2:0]);
        else n_pass++;
      end
    end
    ext_hold = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL timeout_pending got %0d unchecked required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    int base;
    exp_t e;
    logic [16:0] o;
    rst = 1'b1; pll_locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    base = cyc;
    push(base + 32, "ar_pulse", pk(3'b111, 1'b0, 1'b0, 1'b1, 8'd1, 3'd4));
    for (int i = 1; i <= 33; i++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs();
        n_checks++;
        if (o !== e.val)
          $display("FAIL %s cyc=%0d got ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d required ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d",
                   e.tag, cyc - base, o[16:14], o[13], o[12], o[11], o[10:3], o[2:0],
                   e.val[16:14], e.val[13], e.val[12], e.val[11], e.val[10:3], e.val[2:0]);
        else n_pass++;
      end
    end
    // Mid-pulse, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    o = obs();
    n_checks++;
    if (o !== pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0))
      $display("FAIL async_rst_pulse got %b required %b", o, pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    else n_pass++;

    pll_locked = 1'b1;
    tick();
    rst = 1'b0;
    base = cyc;
    push(base + 15, "ar_rel0", pk(3'b110, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2));
    for (int i = 1; i <= 16; i++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        o = obs();
        n_checks++;
        if (o !== e.val)
          $display("FAIL %s cyc=%0d got ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d required ro=%b sd=%b ll=%b pr=%b rc=%0d st=%0d",
                   e.tag, cyc - base, o[16:14], o[13], o[12], o[11], o[10:3], o[2:0],
                   e.val[16:14], e.val[13], e.val[12], e.val[11], e.val[10:3], e.val[2:0]);
        else n_pass++;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    o = obs();
    n_checks++;
    if (o !== pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0))
      $display("FAIL async_rst_release got %b required %b", o, pk(3'b111, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0));
    else n_pass++;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL async_pending got %0d unchecked required 0", sb.size());
      sb.delete();
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    rst           = 1'b1;
    pll_locked    = 1'b0;
    ext_hold      = 1'b0;
    clr_lock_lost = 1'b0;
    test_reset();
    test_nominal();
    test_hold();
    test_glitch();
    test_lock_loss();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
